cache_plru_4way: RTL

CACHE_PLRU_4WAY -- requirements
Module: cache_plru_4way

---
 rtl/cache_plru_4way_if.sv | 26 ++
 rtl/cache_plru_4way.sv | 101 ++++++++++
 2 files changed

// File: rtl/cache_plru_4way_if.sv
// Request/update/victim bundle for the 4-way tree-PLRU replacement tracker.
// The cache controller drives the master side; the tracker is the slave.
interface cache_plru_4way_if #(
    parameter int INDEX_W = 8
);
    logic               flush;
    logic               ready;
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_index;
    logic [1:0]         upd_way;
    logic               req_valid;
    logic [INDEX_W-1:0] req_index;
    logic [3:0]         req_way_valid;
    logic               victim_valid;
    logic [1:0]         victim_way;

    modport master (
        output flush, upd_valid, upd_index, upd_way, req_valid, req_index, req_way_valid,
        input  ready, victim_valid, victim_way
    );

    modport slave (
        input  flush, upd_valid, upd_index, upd_way, req_valid, req_index, req_way_valid,
        output ready, victim_valid, victim_way
    );
endinterface

// File: rtl/cache_plru_4way.sv
// Per-set 3-bit tree-PLRU tracker for a 4-way cache: victim selection with
// invalid-way priority, access updates, and a one-set-per-cycle clear sequence.
module cache_plru_4way #(
    parameter int SET_NUM = 256,
    parameter int INDEX_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    cache_plru_4way_if.slave bus
);
    typedef enum logic {INIT, RUN} state_e;

    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SET_NUM - 1);

    state_e             state_q;
    logic [INDEX_W-1:0] cnt_q;
    logic               ready_q;
    logic               victim_valid_q;
    logic [1:0]         victim_way_q;

    // Bit order per set is {b2, b1, b0}.
    logic [2:0]         plru_q [SET_NUM];

    logic [2:0] req_bits;
    logic [2:0] upd_bits;
    logic [2:0] upd_bits_d;
    logic [1:0] victim_d;
    logic       req_acc;
    logic       upd_acc;
    logic       clr_en;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        req_acc  = ready_q & ~bus.flush & bus.req_valid;
        upd_acc  = ready_q & ~bus.flush & bus.upd_valid;
        clr_en   = (state_q == INIT) & ~bus.flush;

        req_bits = plru_q[bus.req_index];
        victim_d = req_bits[0] ? {1'b1, req_bits[2]} : {1'b0, req_bits[1]};
        if (bus.req_way_valid != 4'b1111) begin
            victim_d = 2'd3;
            for (int i = 3; i >= 0; i--) begin
                if (!bus.req_way_valid[i]) victim_d = 2'(i);
            end
        end

        upd_bits      = plru_q[bus.upd_index];
        upd_bits_d    = upd_bits;
        upd_bits_d[0] = ~bus.upd_way[1];
        if (!bus.upd_way[1]) upd_bits_d[1] = ~bus.upd_way[0];
        else                 upd_bits_d[2] = ~bus.upd_way[0];
    end

    // NOTE: the PLRU array has no reset branch; INIT walks every set to zero
    // instead, which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (clr_en)       plru_q[cnt_q]         <= '0;
            else if (upd_acc) plru_q[bus.upd_index] <= upd_bits_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= INIT;
            cnt_q          <= '0;
            ready_q        <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= 2'b00;
        end else if (bus.flush) begin
            state_q        <= INIT;
            cnt_q          <= '0;
            ready_q        <= 1'b0;
            victim_valid_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    victim_valid_q <= 1'b0;
                    if (cnt_q == LAST_SET) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    victim_valid_q <= req_acc;
                    if (req_acc) victim_way_q <= victim_d;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
endmodule
